// File: rtl/conv_window_loader_pkg.sv
// Shared convolution datapath types: word width, window containers and the
// window-loader state encoding.
package packConv;

    localparam int NBITS      = 20;
    localparam int WIN3_WORDS = 9;
    localparam int WIN5_WORDS = 25;

    typedef logic [NBITS-1:0] regC;
    typedef regC [0:WIN5_WORDS-1] param25;

    typedef enum logic [1:0] {
        W_IDLE,
        W_LOAD,
        W_FULL
    } win_states;

    // Index of the final word of a window for the given size flag.
    function automatic logic [4:0] lastIndex(input logic size);
        return size ? 5'(WIN5_WORDS - 1) : 5'(WIN3_WORDS - 1);
    endfunction

endpackage

// File: rtl/conv_window_loader.sv
// Collects a 3x3 or 5x5 pixel window word by word (row-major) and presents it
// as one parallel window to the convolution core.
module conv_window_loader
    import packConv::*;
(
    input  logic   clock,
    input  logic   reset,
    input  logic   mode,
    input  logic   in_valid,
    output logic   in_ready,
    input  regC    in_data,
    output logic   win_valid,
    input  logic   win_ready,
    output param25 win_data,
    output logic   win_size,
    output logic   busy
);

    // Handshakes: a transfer happens on a cycle where valid and ready are both
    // high at the rising clock edge; valid never depends on ready.
    win_states  state;
    win_states  stateNext;
    logic [4:0] count;
    logic       wordAccept;
    logic       lastWord;

    assign in_ready   = (state != W_FULL);
    assign win_valid  = (state == W_FULL);
    assign busy       = (state != W_IDLE);
    assign wordAccept = in_valid && in_ready;
    assign lastWord   = (count == lastIndex(win_size));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= W_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            W_IDLE: begin
                if (wordAccept) begin
                    stateNext = W_LOAD;
                end
            end
            W_LOAD: begin
                if (wordAccept && lastWord) begin
                    stateNext = W_FULL;
                end
            end
            W_FULL: begin
                if (win_ready) begin
                    stateNext = W_IDLE;
                end
            end
            default: stateNext = W_IDLE;
        endcase
    end

    // Window storage; mode is latched only with the first word so later
    // toggles cannot change the size of a window in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count    <= '0;
            win_size <= 1'b0;
            win_data <= '0;
        end else begin
            case (state)
                W_IDLE: begin
                    if (wordAccept) begin
                        win_size    <= mode;
                        win_data    <= '0;
                        win_data[0] <= in_data;
                        count       <= 5'd1;
                    end
                end
                W_LOAD: begin
                    if (wordAccept) begin
                        win_data[count] <= in_data;
                        count           <= lastWord ? 5'd0 : count + 5'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
